// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter.
// The FSM walks IDLE -> ISSUE -> WAIT once per memory transaction.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Counts consecutive data-side grants taken while a fetch was waiting.
// o_if_priority tells the arbiter to serve the fetch next.
module arb_streak_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_grant_dm,
  input  logic i_grant_if,
  input  logic i_if_req,
  output logic o_if_priority
);

  localparam logic [STREAK_W-1:0] MAX_CNT = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] streak;

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      streak <= '0;
    end else if (i_grant_if || (i_grant_dm && !i_if_req)) begin
      streak <= '0;
    end else if (i_grant_dm && (streak < MAX_CNT)) begin
      streak <= streak + STREAK_W'(1);
    end
  end

  assign o_if_priority = (streak >= MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and
// load/store, with one transaction outstanding and stall outputs for hazards.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_kill,
  output logic [DATA_W-1:0]   o_if_rdata,
  output logic                o_if_ack,
  input  logic                i_dm_req,
  input  logic                i_dm_wren,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  input  logic [DATA_W/8-1:0] i_dm_bmask,
  output logic [DATA_W-1:0]   o_dm_rdata,
  output logic                o_dm_ack,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wren,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_stall_if,
  output logic                o_stall_mem
);

  arb_state_e state, state_next;
  arb_owner_e owner;
  logic       killed;
  logic       if_priority;
  logic       grant_dm;
  logic       grant_if;
  logic       mem_done;

  arb_streak_ctr #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_streak (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_grant_dm   (grant_dm),
    .i_grant_if   (grant_if),
    .i_if_req     (i_if_req),
    .o_if_priority(if_priority)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaults come first so every path assigns and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    mem_done   = 1'b0;
    case (state)
      IDLE: begin
        if (i_dm_req && (!i_if_req || !if_priority)) begin
          grant_dm   = 1'b1;
          state_next = ISSUE;
        end else if (i_if_req && !i_if_kill) begin
          grant_if   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (i_mem_ack) begin
          mem_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner       <= OWN_IF;
      killed      <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wren  <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_if_rdata  <= '0;
      o_dm_rdata  <= '0;
      o_if_ack    <= 1'b0;
      o_dm_ack    <= 1'b0;
    end else begin
      o_if_ack <= 1'b0;
      o_dm_ack <= 1'b0;

      if (grant_dm) begin
        owner       <= OWN_DM;
        o_mem_addr  <= i_dm_addr;
        o_mem_wren  <= i_dm_wren;
        o_mem_wdata <= i_dm_wdata;
        o_mem_bmask <= i_dm_bmask;
      end else if (grant_if) begin
        owner       <= OWN_IF;
        o_mem_addr  <= i_if_addr;
        o_mem_wren  <= 1'b0;
        o_mem_wdata <= '0;
        o_mem_bmask <= '0;
      end

      // A flush while a fetch is in flight turns its completion into a silent drain.
      if (mem_done) begin
        killed <= 1'b0;
      end else if ((state != IDLE) && (owner == OWN_IF) && i_if_kill) begin
        killed <= 1'b1;
      end

      if (mem_done) begin
        if (owner == OWN_DM) begin
          o_dm_ack <= 1'b1;
          if (!o_mem_wren) begin
            o_dm_rdata <= i_mem_rdata;
          end
        end else begin
          o_if_rdata <= i_mem_rdata;
          o_if_ack   <= !(killed || i_if_kill);
        end
      end
    end
  end

  assign o_mem_req   = (state == ISSUE);
  assign o_stall_if  = i_if_req & ~o_if_ack & ~i_if_kill;
  assign o_stall_mem = i_dm_req & ~o_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: stall table, directed multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_wren;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_bmask;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_DM_STREAK(MAX_STREAK)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .i_if_kill  (if_kill),
    .o_if_rdata (if_rdata),
    .o_if_ack   (if_ack),
    .i_dm_req   (dm_req),
    .i_dm_wren  (dm_wren),
    .i_dm_addr  (dm_addr),
    .i_dm_wdata (dm_wdata),
    .i_dm_bmask (dm_bmask),
    .o_dm_rdata (dm_rdata),
    .o_dm_ack   (dm_ack),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .o_mem_wren (mem_wren),
    .o_mem_wdata(mem_wdata),
    .o_mem_bmask(mem_bmask),
    .i_mem_ack  (mem_ack),
    .i_mem_rdata(mem_rdata),
    .o_stall_if (stall_if),
    .o_stall_mem(stall_mem)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_kill = 0;
    dm_req = 0; dm_wren = 0; dm_addr = '0; dm_wdata = '0; dm_bmask = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1;
    idle_inputs();
    cyc();
    cyc();
    reset = 0;
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  typedef struct packed {
    logic req_if;
    logic kill;
    logic req_dm;
    logic exp_stall_if;
    logic exp_stall_mem;
  } stall_vec_t;

  stall_vec_t vecs[8];

  // Reference model state for the random phase.
  bit          busy, expect_req, m_owner_dm, m_killed, m_wren;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_bmask;
  int          m_streak, grant_cyc, cyc_no, countdown;
  bit          exp_if_ack, exp_dm_ack;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  bit          if_acked_prev, dm_acked_prev, kill_prev;

  logic [31:0] order[6];
  int          n_grants;
  bit          ack_next;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_inputs();

    // ---------------- reset state and stall table (reset held) ----------------
    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 1, 0};
    vecs[2] = '{1, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 0, 1};
    vecs[5] = '{1, 0, 1, 1, 1};
    vecs[6] = '{1, 1, 1, 0, 1};
    vecs[7] = '{0, 1, 1, 0, 1};
    cyc(); cyc(); sample();
    check("reset mem_req", mem_req, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wren", mem_wren, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset mem_bmask", mem_bmask, 0);
    check("reset if_ack", if_ack, 0);
    check("reset dm_ack", dm_ack, 0);
    check("reset if_rdata", if_rdata, 0);
    check("reset dm_rdata", dm_rdata, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if_req  = vecs[i].req_if;
      if_kill = vecs[i].kill;
      dm_req  = vecs[i].req_dm;
      sample();
      check($sformatf("table[%0d] stall_if", i), stall_if, vecs[i].exp_stall_if);
      check($sformatf("table[%0d] stall_mem", i), stall_mem, vecs[i].exp_stall_mem);
    end

    // ---------------- single fetch, minimum latency ----------------
    do_reset();
    cyc(); if_req = 1; if_addr = 32'h10; sample();
    check("fetch N stall_if", stall_if, 1);
    check("fetch N mem_req", mem_req, 0);
    cyc(); sample();
    check("fetch N+1 mem_req", mem_req, 1);
    check("fetch N+1 mem_addr", mem_addr, 32'h10);
    check("fetch N+1 mem_wren", mem_wren, 0);
    check("fetch N+1 stall_if", stall_if, 1);
    cyc(); mem_ack = 1; mem_rdata = 32'h93; sample();
    check("fetch N+2 mem_req", mem_req, 0);
    check("fetch N+2 if_ack", if_ack, 0);
    check("fetch N+2 stall_if", stall_if, 1);
    cyc(); mem_ack = 0; mem_rdata = '0; sample();
    check("fetch N+3 if_ack", if_ack, 1);
    check("fetch N+3 if_rdata", if_rdata, 32'h93);
    check("fetch N+3 stall_if", stall_if, 0);
    cyc(); if_req = 0; sample();
    check("fetch N+4 if_ack", if_ack, 0);

    // ---------------- streak limit: DM x4, IF, DM ----------------
    do_reset();
    for (int i = 0; i < 6; i++) order[i] = '0;
    n_grants = 0;
    ack_next = 0;
    cyc();
    if_req = 1; if_addr = 32'h400;
    dm_req = 1; dm_wren = 0; dm_addr = 32'h800;
    for (int c = 0; c < 60 && n_grants < 6; c++) begin
      if (c > 0) cyc();
      mem_ack   = ack_next;
      mem_rdata = 32'h1;
      ack_next  = 0;
      sample();
      if (mem_req) begin
        order[n_grants] = mem_addr;
        n_grants++;
        ack_next = 1;
      end
    end
    check("streak grants seen", n_grants, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("streak grant[%0d] addr", i), order[i], (i == 4) ? 32'h400 : 32'h800);

    // ---------------- store held through WAIT ----------------
    do_reset();
    cyc();
    dm_req = 1; dm_wren = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_bmask = 4'h3;
    sample();
    check("store N stall_mem", stall_mem, 1);
    cyc(); sample();
    check("store issue mem_req", mem_req, 1);
    check("store issue wren", mem_wren, 1);
    check("store issue addr", mem_addr, 32'h100);
    check("store issue wdata", mem_wdata, 32'hDEAD_BEEF);
    check("store issue bmask", mem_bmask, 4'h3);
    for (int k = 2; k <= 3; k++) begin
      cyc(); sample();
      check("store wait mem_req", mem_req, 0);
      check("store wait wren", mem_wren, 1);
      check("store wait addr", mem_addr, 32'h100);
      check("store wait wdata", mem_wdata, 32'hDEAD_BEEF);
      check("store wait bmask", mem_bmask, 4'h3);
      check("store wait dm_ack", dm_ack, 0);
    end
    cyc(); mem_ack = 1; mem_rdata = 32'h1234_5678; sample();
    cyc(); mem_ack = 0; sample();
    check("store dm_ack", dm_ack, 1);
    check("store dm_rdata untouched", dm_rdata, 0);
    check("store ack stall_mem", stall_mem, 0);

    // ---------------- kill in WAIT, late ack, then fresh fetch ----------------
    do_reset();
    cyc(); if_req = 1; if_addr = 32'h40; sample();
    cyc(); sample();
    check("kill issue mem_req", mem_req, 1);
    cyc(); if_kill = 1; sample();
    check("kill cycle stall_if", stall_if, 0);
    for (int k = 3; k <= 8; k++) begin
      cyc();
      if_kill   = 0;
      if_req    = (k == 8);
      if_addr   = 32'h200;
      mem_ack   = (k == 7);
      mem_rdata = 32'h55;
      sample();
      check($sformatf("kill N+%0d if_ack", k), if_ack, 0);
      check($sformatf("kill N+%0d mem_req", k), mem_req, 0);
    end
    cyc(); mem_ack = 0; sample();
    check("refetch mem_req", mem_req, 1);
    check("refetch mem_addr", mem_addr, 32'h200);
    cyc(); mem_ack = 1; mem_rdata = 32'h13; sample();
    cyc(); mem_ack = 0; sample();
    check("refetch if_ack", if_ack, 1);
    check("refetch if_rdata", if_rdata, 32'h13);

    // ---------------- reset during WAIT, stale ack afterwards ----------------
    do_reset();
    cyc(); dm_req = 1; dm_wren = 0; dm_addr = 32'h300; sample();
    cyc(); sample();
    check("rst issue mem_addr", mem_addr, 32'h300);
    cyc(); sample();
    cyc(); reset = 1; sample();
    cyc(); reset = 0; dm_req = 0; mem_ack = 1; mem_rdata = 32'hBAD; sample();
    check("rst idle mem_req", mem_req, 0);
    check("rst idle mem_addr", mem_addr, 0);
    check("rst idle mem_wren", mem_wren, 0);
    check("rst idle mem_wdata", mem_wdata, 0);
    check("rst idle mem_bmask", mem_bmask, 0);
    check("rst idle dm_ack", dm_ack, 0);
    check("rst idle if_ack", if_ack, 0);
    check("rst idle dm_rdata", dm_rdata, 0);
    check("rst idle if_rdata", if_rdata, 0);
    cyc(); mem_ack = 0; if_req = 1; if_addr = 32'h600; sample();
    check("rst stale dm_ack", dm_ack, 0);
    check("rst stale dm_rdata", dm_rdata, 0);
    check("rst stale mem_req", mem_req, 0);
    cyc(); sample();
    check("rst next fetch mem_req", mem_req, 1);
    check("rst next fetch addr", mem_addr, 32'h600);

    // ---------------- ack and kill together, pending DM wins IDLE ----------------
    do_reset();
    cyc(); if_req = 1; if_addr = 32'h80; sample();
    cyc(); dm_req = 1; dm_wren = 0; dm_addr = 32'h500; sample();
    check("ackkill issue addr", mem_addr, 32'h80);
    cyc(); mem_ack = 1; mem_rdata = 32'h77; if_kill = 1; sample();
    cyc(); mem_ack = 0; if_kill = 0; if_req = 0; sample();
    check("ackkill if_ack", if_ack, 0);
    cyc(); sample();
    check("ackkill dm mem_req", mem_req, 1);
    check("ackkill dm mem_addr", mem_addr, 32'h500);
    check("ackkill dm mem_wren", mem_wren, 0);
    cyc(); mem_ack = 1; mem_rdata = 32'hABC; sample();
    cyc(); mem_ack = 0; sample();
    check("ackkill dm_ack", dm_ack, 1);
    check("ackkill dm_rdata", dm_rdata, 32'hABC);

    // ---------------- randomized traffic vs. transaction model ----------------
    do_reset();
    busy = 0; expect_req = 0; m_killed = 0; m_owner_dm = 0; m_wren = 0;
    m_addr = '0; m_wdata = '0; m_bmask = '0; m_streak = 0; grant_cyc = 0;
    exp_if_ack = 0; exp_dm_ack = 0; exp_if_rdata = '0; exp_dm_rdata = '0;
    if_acked_prev = 0; dm_acked_prev = 0; kill_prev = 0; countdown = 0;
    for (cyc_no = 0; cyc_no < 1500; cyc_no++) begin
      cyc();
      if (!(if_req && !if_acked_prev && !kill_prev)) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = $urandom;
      end
      if_kill = ($urandom_range(0, 99) < 6);
      if (!(dm_req && !dm_acked_prev)) begin
        dm_req   = ($urandom_range(0, 99) < 50);
        dm_wren  = 1'($urandom_range(0, 1));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_bmask = 4'($urandom_range(0, 15));
      end
      mem_ack   = 0;
      mem_rdata = $urandom;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mem_ack   = 1;
          mem_rdata = mem_data(m_addr);
        end
      end
      sample();

      check("rand stall_if", stall_if, if_req & ~exp_if_ack & ~if_kill);
      check("rand stall_mem", stall_mem, dm_req & ~exp_dm_ack);
      check("rand mem_req", mem_req, expect_req);
      check("rand if_ack", if_ack, exp_if_ack);
      check("rand dm_ack", dm_ack, exp_dm_ack);
      if (exp_if_ack) check("rand if_rdata", if_rdata, exp_if_rdata);
      if (exp_dm_ack) check("rand dm_rdata", dm_rdata, exp_dm_rdata);
      if (expect_req) begin
        check("rand mem_addr", mem_addr, m_addr);
        check("rand mem_wren", mem_wren, m_wren);
        if (m_owner_dm && m_wren) begin
          check("rand mem_wdata", mem_wdata, m_wdata);
          check("rand mem_bmask", mem_bmask, m_bmask);
        end
        countdown = $urandom_range(1, 4);
      end

      if_acked_prev = exp_if_ack;
      dm_acked_prev = exp_dm_ack;
      kill_prev     = if_kill;
      exp_if_ack    = 0;
      exp_dm_ack    = 0;
      expect_req    = 0;
      if (busy) begin
        if (!m_owner_dm && if_kill) m_killed = 1;
        if ((cyc_no > grant_cyc + 1) && mem_ack) begin
          busy = 0;
          if (m_owner_dm) begin
            exp_dm_ack = 1;
            if (!m_wren) exp_dm_rdata = mem_rdata;
          end else begin
            exp_if_rdata = mem_rdata;
            exp_if_ack   = !m_killed;
          end
        end
      end else if (dm_req && (!if_req || m_streak < MAX_STREAK)) begin
        busy = 1; expect_req = 1; grant_cyc = cyc_no; m_killed = 0;
        m_owner_dm = 1; m_addr = dm_addr; m_wren = dm_wren;
        m_wdata = dm_wdata; m_bmask = dm_bmask;
        m_streak = if_req ? ((m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1) : 0;
      end else if (if_req && !if_kill) begin
        busy = 1; expect_req = 1; grant_cyc = cyc_no; m_killed = 0;
        m_owner_dm = 0; m_addr = if_addr; m_wren = 0;
        m_wdata = '0; m_bmask = '0;
        m_streak = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported, variable-latency memory between the pipeline's instruction-fetch stage and its load/store stage. It grants one requester at a time and keeps exactly one memory transaction outstanding. It generates the fetch and memory-stage stall signals that feed the hazard logic. It sits between the IF/MEM stages and the unified memory, and lets the pipelined core run on a shared memory instead of split imem/dmem.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits (1..15)
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request; held with stable address until o_if_ack or i_if_kill
- i_if_addr  in  ADDR_W  fetch address (PC)
- i_if_kill  in  1  fetch cancelled (branch taken / flush)
- o_if_rdata  out  DATA_W  fetched instruction; valid with o_if_ack
- o_if_ack  out  1  one-cycle fetch completion pulse
- i_dm_req  in  1  load/store request; held stable until o_dm_ack
- i_dm_wren  in  1  1 = store
- i_dm_addr  in  ADDR_W  data address
- i_dm_wdata  in  DATA_W  store data
- i_dm_bmask  in  DATA_W/8  store byte enables
- o_dm_rdata  out  DATA_W  load data; valid with o_dm_ack
- o_dm_ack  out  1  one-cycle data completion pulse
- o_mem_req  out  1  one-cycle issue pulse to memory
- o_mem_addr, o_mem_wren, o_mem_wdata, o_mem_bmask  out  ADDR_W/1/DATA_W/DATA_W/8  captured request fields; held until ack
- i_mem_ack  in  1  memory completion pulse
- i_mem_rdata  in  DATA_W  memory read data; valid with i_mem_ack
- o_stall_if  out  1  = i_if_req & ~o_if_ack & ~i_if_kill
- o_stall_mem  out  1  = i_dm_req & ~o_dm_ack

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: grant decision.
  - If i_dm_req and (~i_if_req or dm_streak < MAX_DM_STREAK), grant DM.
  - Else if i_if_req & ~i_if_kill, grant IF.
  - Else stay in IDLE.
  - On grant: capture owner and request fields, go to ISSUE.
- ISSUE: o_mem_req = 1 for exactly this cycle, then go to WAIT.
- WAIT: hold o_mem_* fields. On i_mem_ack:
  - Register i_mem_rdata into the owner's rdata.
  - Pulse the owner's ack next cycle, unless the owner is IF and killed.
  - Go to IDLE.
- Kill: i_if_kill during ISSUE/WAIT with owner IF sets a `killed` flag. The matching ack is consumed silently and o_if_ack stays 0. The flag clears on return to IDLE.
- dm_streak (4-bit):
  - +1 on a DM grant while i_if_req is high.
  - Cleared on an IF grant, or on a DM grant while i_if_req is low.
  - Saturates at MAX_DM_STREAK.
- Stores: i_mem_rdata is ignored, but o_dm_ack still pulses.
- i_mem_ack in IDLE or ISSUE is ignored. This covers stale acks after reset.
- Reset:
  - State IDLE; dm_streak and `killed` = 0.
  - All outputs 0, including rdata and the o_mem_* fields.
  - Any in-flight transaction is dropped.

## Timing
- Request sampled at edge N → ISSUE (o_mem_req = 1) in cycle N+1.
- Earliest i_mem_ack is cycle N+2, giving owner ack in cycle N+3. Minimum latency is 3 cycles; each additional memory wait cycle adds 1.
- Owner ack cycle is also the IDLE cycle. A new grant is decided there, so back-to-back transactions issue every 3 cycles at best.
- A requester may drop or change its request in the cycle after its ack.
- Simultaneous i_if_kill and i_mem_ack (owner IF): the ack is suppressed.
- i_if_kill in IDLE blocks an IF grant that cycle only.
- Reset asserted during WAIT: next cycle is IDLE with no ack pulse.

## Structure
- The shared core package holds the `arb_state_e` enum (IDLE/ISSUE/WAIT) and the `arb_owner_e` enum (OWN_IF/OWN_DM).
- One sub-module, `arb_streak_ctr`: the saturating streak counter, with compare output `o_if_priority`.
- The remaining logic (FSM, capture registers, stall equations) stays in the top.

## Test plan
- Single fetch, 0x0000_0010, memory acks 1 cycle after o_mem_req with 0x0000_0093 → o_if_ack in cycle N+3, o_if_rdata = 0x93, o_stall_if high through cycles N..N+2.
- Fetch and load simultaneous, continuously, MAX_DM_STREAK = 4 → grant order DM, DM, DM, DM, IF, then DM resumes.
- Store 0xDEAD_BEEF to 0x100 with bmask 0x3 → o_mem_wren = 1, o_mem_wdata/bmask match and are held through WAIT, o_dm_ack after ack.
- Fetch issued, i_if_kill in WAIT, ack 5 cycles later → no o_if_ack, return to IDLE; next fetch 0x200 served normally.
- Reset during WAIT of a load, stale i_mem_ack the following cycle → all outputs 0, no ack, FSM IDLE.
- i_mem_ack and i_if_kill in the same cycle (owner IF) → o_if_ack stays 0, and a pending DM request is granted in the IDLE cycle.
